// File: rtl/volume_pkg.sv
// Shared constants, state encoding and the volume ballistics rule for volume_meter.
package volume_pkg;

    localparam logic [11:0] MIC_MIDPOINT = 12'd2048;
    localparam logic [3:0]  VOL_MAX      = 4'd15;
    localparam int          LEVEL_SHIFT  = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2
    } state_e;

    // Fast attack to the window peak, slow release of one step per window.
    function automatic logic [3:0] next_volume(input logic [3:0] peak,
                                               input logic [3:0] cur);
        logic [3:0] nxt;
        if (peak >= cur) begin
            nxt = peak;
        end else begin
            nxt = cur - 4'd1;
        end
        if (nxt > VOL_MAX) begin
            nxt = VOL_MAX;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mic_level.sv
// Folds a 12-bit offset-binary microphone sample around its midpoint and maps the
// 11-bit magnitude to a coarse 4-bit level (truncating, no rounding).
module mic_level
    import volume_pkg::*;
(
    input  logic [11:0] mic_in,
    output logic [3:0]  level
);

    logic [11:0] diff;
    logic [10:0] mag;

    // Below the midpoint the fold uses 2047-x so both halves span 0..2047.
    always_comb begin
        if (mic_in >= MIC_MIDPOINT) begin
            diff = mic_in - MIC_MIDPOINT;
        end else begin
            diff = (MIC_MIDPOINT - 12'd1) - mic_in;
        end
    end

    assign mag   = 11'(diff);
    assign level = 4'(mag >> LEVEL_SHIFT);

endmodule

// File: rtl/volume_meter.sv
// Windowed peak meter: tracks the loudest sample level per window, then applies
// attack/decay ballistics to a displayed volume once per window.
module volume_meter
    import volume_pkg::*;
#(
    parameter int WINDOW_SAMPLES = 4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] mic_in,
    input  logic        sample_valid,
    input  logic        freeze,
    output logic [4:0]  volume,
    output logic        volume_valid,
    output logic [3:0]  peak_level
);

    localparam logic [15:0] WINDOW_LAST = 16'(WINDOW_SAMPLES);

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [3:0]  peak_q, peak_d;
    logic [3:0]  peak_level_q, peak_level_d;
    logic [3:0]  volume_q, volume_d;
    logic        volume_valid_q, volume_valid_d;

    logic [3:0]  sample_level;
    logic [15:0] count_inc;

    mic_level u_mic_level (
        .mic_in (mic_in),
        .level  (sample_level)
    );

    assign count_inc = count_q + 16'd1;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d        = state_q;
        count_d        = count_q;
        peak_d         = peak_q;
        peak_level_d   = peak_level_q;
        volume_d       = volume_q;
        volume_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    peak_d  = sample_level;
                    count_d = 16'd1;
                    state_d = ACCUM;
                end
            end

            ACCUM: begin
                if (sample_valid) begin
                    peak_d  = (sample_level > peak_q) ? sample_level : peak_q;
                    count_d = count_inc;
                    if (count_inc == WINDOW_LAST) begin
                        state_d = UPDATE;
                    end
                end
            end

            UPDATE: begin
                peak_level_d = peak_q;
                if (!freeze) begin
                    volume_d       = next_volume(peak_q, volume_q);
                    volume_valid_d = 1'b1;
                end
                // A sample landing on the boundary opens the next window rather than being lost.
                if (sample_valid) begin
                    peak_d  = sample_level;
                    count_d = 16'd1;
                end else begin
                    peak_d  = 4'd0;
                    count_d = 16'd0;
                end
                state_d = ACCUM;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            count_q        <= 16'd0;
            peak_q         <= 4'd0;
            peak_level_q   <= 4'd0;
            volume_q       <= 4'd0;
            volume_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            peak_q         <= peak_d;
            peak_level_q   <= peak_level_d;
            volume_q       <= volume_d;
            volume_valid_q <= volume_valid_d;
        end
    end

    assign volume       = {1'b0, volume_q};
    assign volume_valid = volume_valid_q;
    assign peak_level   = peak_level_q;

endmodule

// File: tb/tb_volume_meter.sv
// Self-checking bench for volume_meter with a 4-sample window; expected pulses are
// queued by each scenario and matched by a monitor as volume_valid fires.
module tb_volume_meter;

    typedef struct {
        logic [4:0] vol;
        logic [3:0] pl;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [11:0] mic_in;
    logic        sample_valid;
    logic        freeze;
    logic [4:0]  volume;
    logic        volume_valid;
    logic [3:0]  peak_level;

    int   checks;
    int   errors;
    int   pulses;
    exp_t exp_q[$];

    volume_meter #(.WINDOW_SAMPLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mic_in       (mic_in),
        .sample_valid (sample_valid),
        .freeze       (freeze),
        .volume       (volume),
        .volume_valid (volume_valid),
        .peak_level   (peak_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (volume_valid === 1'b1) begin
            exp_t e;
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: volume=%0d peak_level=%0d, required no pulse", volume, peak_level);
            end else begin
                e = exp_q.pop_front();
                if (volume !== e.vol || peak_level !== e.pl) begin
                    errors++;
                    $display("FAIL pulse_value: volume=%0d peak_level=%0d, required volume=%0d peak_level=%0d",
                             volume, peak_level, e.vol, e.pl);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] s);
        mic_in       = s;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        mic_in       = 12'd4095;
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        mic_in       = 12'd4095;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic expect_pulses(input string name, input int start, input int want);
        checks++;
        if (pulses - start !== want) begin
            errors++;
            $display("FAIL %s: pulses=%0d, required %0d", name, pulses - start, want);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        sample_valid = 1'b1;
        mic_in       = 12'd4095;
        freeze       = 1'b0;
        tick();
        tick();
        sample_valid = 1'b0;
        tick();
        checks += 3;
        if (volume !== 5'd0) begin
            errors++;
            $display("FAIL reset_volume: got %0d, required 0", volume);
        end
        if (peak_level !== 4'd0) begin
            errors++;
            $display("FAIL reset_peak_level: got %0d, required 0", peak_level);
        end
        if (volume_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_volume_valid: got %b, required 0", volume_valid);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_silence();
        int start = pulses;
        exp_q.push_back('{vol: 5'd0, pl: 4'd0});
        for (int i = 0; i < 4; i++) send(12'd2048);
        idle(3);
        expect_pulses("silence_pulses", start, 1);
    endtask

    task automatic test_peak_latency();
        int start = pulses;
        exp_q.push_back('{vol: 5'd15, pl: 4'd15});
        send(12'd2048);
        send(12'd4095);
        send(12'd2048);
        send(12'd0);
        checks += 4;
        if (volume_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: volume_valid=%b one cycle after close, required 0", volume_valid);
        end
        tick();
        if (volume_valid !== 1'b1 || volume !== 5'd15) begin
            errors++;
            $display("FAIL latency_pulse: volume_valid=%b volume=%0d, required 1 and 15", volume_valid, volume);
        end
        if (peak_level !== 4'd15) begin
            errors++;
            $display("FAIL peak_level_15: got %0d, required 15", peak_level);
        end
        tick();
        if (volume_valid !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: volume_valid=%b, required 0", volume_valid);
        end
        expect_pulses("peak_pulses", start, 1);
    endtask

    task automatic test_decay();
        int start = pulses;
        for (int w = 0; w < 3; w++) begin
            exp_q.push_back('{vol: 5'(14 - w), pl: 4'd0});
            for (int i = 0; i < 4; i++) begin
                send(12'd2048);
                idle(1);
            end
            idle(2);
        end
        expect_pulses("decay_pulses", start, 3);
        checks++;
        if (volume !== 5'd12) begin
            errors++;
            $display("FAIL decay_final: volume=%0d, required 12", volume);
        end
    endtask

    task automatic test_freeze();
        int start;
        do_reset();
        start  = pulses;
        freeze = 1'b1;
        for (int i = 0; i < 4; i++) send(12'd3000);
        idle(3);
        freeze = 1'b0;
        expect_pulses("freeze_no_pulse", start, 0);
        checks += 2;
        if (volume !== 5'd0) begin
            errors++;
            $display("FAIL freeze_volume: got %0d, required 0", volume);
        end
        if (peak_level !== 4'd7) begin
            errors++;
            $display("FAIL freeze_peak_level: got %0d, required 7", peak_level);
        end
        exp_q.push_back('{vol: 5'd7, pl: 4'd7});
        for (int i = 0; i < 4; i++) send(12'd3000);
        idle(3);
        expect_pulses("unfreeze_pulse", start, 1);
    endtask

    task automatic test_back_to_back();
        logic [11:0] samples [12];
        int start;
        samples = '{12'd2048, 12'd2048, 12'd2048, 12'd2048,
                    12'd4095, 12'd2048, 12'd2048, 12'd2048,
                    12'd2432, 12'd2048, 12'd2048, 12'd2048};
        do_reset();
        start = pulses;
        exp_q.push_back('{vol: 5'd0,  pl: 4'd0});
        exp_q.push_back('{vol: 5'd15, pl: 4'd15});
        exp_q.push_back('{vol: 5'd14, pl: 4'd3});
        sample_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            mic_in = samples[i];
            tick();
        end
        idle(4);
        expect_pulses("back_to_back_pulses", start, 3);
    endtask

    task automatic test_reset_mid_window();
        int start;
        send(12'd4095);
        send(12'd4095);
        rst_n        = 1'b0;
        sample_valid = 1'b1;
        mic_in       = 12'd4095;
        tick();
        rst_n        = 1'b1;
        sample_valid = 1'b0;
        start        = pulses;
        checks += 2;
        if (volume !== 5'd0) begin
            errors++;
            $display("FAIL midreset_volume: got %0d, required 0", volume);
        end
        if (peak_level !== 4'd0) begin
            errors++;
            $display("FAIL midreset_peak_level: got %0d, required 0", peak_level);
        end
        for (int i = 0; i < 3; i++) send(12'd2048);
        idle(3);
        expect_pulses("midreset_no_early_pulse", start, 0);
        exp_q.push_back('{vol: 5'd0, pl: 4'd0});
        send(12'd2048);
        idle(3);
        expect_pulses("midreset_pulse", start, 1);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        pulses       = 0;
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        freeze       = 1'b0;
        mic_in       = 12'd2048;

        test_reset();
        test_silence();
        test_peak_latency();
        test_decay();
        test_freeze();
        test_back_to_back();
        test_reset_mid_window();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected pulses never seen, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
